// File: rtl/csi2tx_ldl_rd_data_pipe.sv
// CSI-2 TX low-level lane distributor: read-data pipeline and packet byte tracking.
// Holds the current and previous FIFO words and decodes each packet header.
// It tracks fetched and delivered byte counts and produces the eop_rd/eop_wr markers.
// Optional macro CSI2TX_LDL_WC_ZERO_CHECK_EN: flag long packets whose WC is zero on pkt_err.
//
// state  | meaning
// IDLE   | no packet in flight, beats ignored
// ACTIVE | packet loaded, counting fetched and delivered bytes
// DRAIN  | last bytes delivered, eop_wr high for this one cycle
module csi2tx_ldl_rd_data_pipe (
    input  logic        txbyteclkhs,
    input  logic        txbyteclkhs_rst_n,
    input  logic        forcetxstopmode,
    input  logic        fifo_rd_en,
    input  logic [63:0] fifo_dout,
    input  logic        header_info,
    input  logic [3:0]  lane_cnt,
    input  logic        txreadyhs0,
    input  logic        txrequesths0,
    output logic [63:0] fifo_rd_data,
    output logic [63:0] fifo_rd_data_d,
    output logic [16:0] validated_word_cnt,
    output logic        short_packet,
    output logic        eop_rd,
    output logic        eop_wr,
    output logic        pkt_err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DRAIN  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic        r_rd_vld_q;
    logic [63:0] r_rd_data;
    logic [63:0] r_rd_data_d;
    logic [16:0] r_vwc;
    logic [16:0] r_fetched;
    logic [16:0] r_total;
    logic        r_short;
    logic        r_eop_wr;

    logic        w_beat;
    logic [16:0] w_lanes;
    logic [16:0] w_dec;
    logic [16:0] w_vwc_dec;
    logic        w_beat_act;
    logic        w_zero_beat;
    logic [15:0] w_wc;
    logic        w_hdr_short;
    logic [16:0] w_hdr_len;
    logic [16:0] w_fetched_inc;

    assign w_beat        = txreadyhs0 & txrequesths0;
    // Out-of-range lane counts behave as a full 8-lane link.
    assign w_lanes       = ((lane_cnt == 4'd0) || (lane_cnt > 4'd8)) ? 17'd8 : {13'd0, lane_cnt};
    assign w_dec         = (r_vwc < w_lanes) ? r_vwc : w_lanes;
    assign w_vwc_dec     = r_vwc - w_dec;
    // A header in the same cycle takes precedence, so the beat is dropped then.
    assign w_beat_act    = w_beat && (r_state == ACTIVE) && !header_info && !forcetxstopmode;
    assign w_zero_beat   = w_beat_act && (w_vwc_dec == 17'd0);
    assign w_wc          = fifo_dout[23:8];
    assign w_hdr_short   = (fifo_dout[5:0] <= 6'h0F);
    assign w_hdr_len     = w_hdr_short ? 17'd4 : (17'd6 + {1'b0, w_wc});
    assign w_fetched_inc = (r_fetched > 17'h1FFF7) ? 17'h1FFFF : (r_fetched + 17'd8);

    assign fifo_rd_data       = r_rd_data;
    assign fifo_rd_data_d     = r_rd_data_d;
    assign validated_word_cnt = r_vwc;
    assign short_packet       = r_short;
    assign eop_wr             = r_eop_wr;
    assign eop_rd             = (r_state == ACTIVE) && (r_fetched >= r_total);

    // State register.
    always_ff @(posedge txbyteclkhs or negedge txbyteclkhs_rst_n) begin
        if (!txbyteclkhs_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: abort beats everything, then header load, then beat progress.
    always_comb begin
        w_state_nxt = r_state;
        if (forcetxstopmode) begin
            w_state_nxt = IDLE;
        end else if (header_info) begin
            w_state_nxt = ACTIVE;
        end else begin
            case (r_state)
                IDLE:    w_state_nxt = IDLE;
                ACTIVE:  if (w_zero_beat) w_state_nxt = DRAIN;
                DRAIN:   w_state_nxt = IDLE;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // Read-data pipe: data lands one cycle after the read strobe; abort leaves it alone.
    always_ff @(posedge txbyteclkhs or negedge txbyteclkhs_rst_n) begin
        if (!txbyteclkhs_rst_n) begin
            r_rd_vld_q  <= 1'b0;
            r_rd_data   <= '0;
            r_rd_data_d <= '0;
        end else begin
            r_rd_vld_q <= fifo_rd_en;
            if (r_rd_vld_q) begin
                r_rd_data   <= fifo_dout;
                r_rd_data_d <= r_rd_data;
            end
        end
    end

    // Packet byte accounting and end-of-packet pulse.
    always_ff @(posedge txbyteclkhs or negedge txbyteclkhs_rst_n) begin
        if (!txbyteclkhs_rst_n) begin
            r_vwc     <= '0;
            r_fetched <= '0;
            r_total   <= '0;
            r_short   <= 1'b0;
            r_eop_wr  <= 1'b0;
        end else begin
            r_eop_wr <= 1'b0;
            if (forcetxstopmode) begin
                r_vwc     <= '0;
                r_fetched <= '0;
                r_total   <= '0;
                r_short   <= 1'b0;
            end else if (header_info) begin
                r_vwc     <= w_hdr_len;
                r_total   <= w_hdr_len;
                r_fetched <= '0;
                r_short   <= w_hdr_short;
            end else begin
                if ((r_state == ACTIVE) && fifo_rd_en) begin
                    r_fetched <= w_fetched_inc;
                end
                if (w_beat_act) begin
                    r_vwc <= w_vwc_dec;
                end
                if (w_zero_beat) begin
                    r_eop_wr <= 1'b1;
                end
            end
        end
    end

`ifdef CSI2TX_LDL_WC_ZERO_CHECK_EN
    logic r_pkt_err;
    assign pkt_err = r_pkt_err;

    // Sticky flag for a long packet announcing zero payload bytes.
    always_ff @(posedge txbyteclkhs or negedge txbyteclkhs_rst_n) begin
        if (!txbyteclkhs_rst_n) begin
            r_pkt_err <= 1'b0;
        end else if (forcetxstopmode) begin
            r_pkt_err <= 1'b0;
        end else if (header_info) begin
            r_pkt_err <= !w_hdr_short && (w_wc == 16'd0);
        end
    end
`else
    assign pkt_err = 1'b0;
`endif

endmodule

// File: doc/csi2tx_ldl_rd_data_pipe.md
CSI2TX_LDL_RD_DATA_PIPE -- requirements
Module: csi2tx_ldl_rd_data_pipe

Interface
REQ-001 SHALL have ports: txbyteclkhs  in  1  byte clock; all logic on its rising edge.
REQ-002 SHALL have ports: txbyteclkhs_rst_n  in  1  asynchronous active-low reset.
REQ-003 SHALL have ports: forcetxstopmode  in  1  synchronous abort.
REQ-004 SHALL have ports: fifo_rd_en  in  1  byte-FIFO read strobe from the lane distributor.
REQ-005 SHALL have ports: fifo_dout  in  64  FIFO read data, valid one cycle after fifo_rd_en.
REQ-006 SHALL have ports: header_info  in  1  strobe; the header word is on fifo_dout this cycle.
REQ-007 SHALL have ports: lane_cnt  in  4  active data lanes, 1..8.
REQ-008 SHALL have ports: txreadyhs0 and txrequesths0  in  1 each  lane-0 handshake.
REQ-009 SHALL have ports: fifo_rd_data and fifo_rd_data_d  out  64 each  current and previous FIFO word.
REQ-010 SHALL have ports: validated_word_cnt  out  17  bytes still to put on lanes.
REQ-011 SHALL have ports: short_packet, eop_rd, eop_wr, pkt_err  out  1 each.

Function
REQ-012 SHALL register rd_vld_q equal to fifo_rd_en delayed by one cycle.
REQ-013 SHALL update both data registers only when rd_vld_q=1:
- fifo_rd_data <= fifo_dout
- fifo_rd_data_d <= old fifo_rd_data
REQ-014 SHALL, when header_info=1, decode fifo_dout[31:0] as DI[7:0], WC[23:8], ECC[31:24].
REQ-015 SHALL set short_packet to (DI[5:0] <= 6'h0F); short_packet holds its value until the next header_info.
REQ-016 SHALL, on header_info, load total_bytes and validated_word_cnt:
- short packet: 4
- long packet: 6 + WC, computed at 17 bits with no overflow
REQ-017 SHALL count fetched bytes in fetched_bytes (17 bits):
- clear it on header_info
- add 8 (saturating at 17'h1FFFF) on each fifo_rd_en while the packet is active
REQ-018 SHALL define a beat as txreadyhs0 & txrequesths0.
REQ-019 SHALL, on each beat, decrement validated_word_cnt by min(validated_word_cnt, lane_cnt); it never goes below 0.
REQ-020 SHALL drive eop_rd combinationally high while the packet is active and fetched_bytes >= total_bytes, which suppresses further FIFO reads.
REQ-021 SHALL pulse eop_wr for exactly one cycle, in the cycle after the beat that brings validated_word_cnt to 0.
REQ-022 SHALL use state machine states IDLE, ACTIVE, DRAIN:
- IDLE -> ACTIVE on header_info
- ACTIVE -> DRAIN on the beat that zeroes the count
- DRAIN -> IDLE after one cycle, the eop_wr cycle
REQ-023 SHALL give header_info priority over a beat if both occur in the same cycle; header_info is the load.
REQ-024 SHALL, on forcetxstopmode=1:
- return to IDLE
- clear validated_word_cnt, fetched_bytes, total_bytes, short_packet, eop_wr and pkt_err
- leave the data registers unchanged
REQ-025 SHALL ignore beats in IDLE.
REQ-026 SHALL treat lane_cnt values of 0 or greater than 8 as 8.

Reset
REQ-027 SHALL, on txbyteclkhs_rst_n=0, asynchronously clear every register:
- fifo_rd_data, fifo_rd_data_d = 0
- validated_word_cnt = 0
- short_packet, eop_rd, eop_wr, pkt_err = 0
- state = IDLE
REQ-028 SHALL abandon a packet when reset is asserted mid-packet, with no eop_wr emitted.

Configuration
REQ-029 SHALL, with macro CSI2TX_LDL_WC_ZERO_CHECK_EN defined, treat a long-packet header with WC=0:
- set pkt_err high, sticky until the next header_info or forcetxstopmode
- still load 6
REQ-030 SHALL, without CSI2TX_LDL_WC_ZERO_CHECK_EN, tie pkt_err to 0 and synthesise no check logic.

Verification
REQ-031 SHALL cover a short packet:
- stimulus: header DI=8'h00, lane_cnt=7, one beat
- required: short_packet=1; count 4 -> 0; eop_wr pulse the next cycle
REQ-032 SHALL cover a long packet:
- stimulus: DI=8'h2A, WC=16'd20, lane_cnt=7
- required: count 26 -> 19 -> 12 -> 5 -> 0 over four beats
- required: eop_rd asserts after the 4th fifo_rd_en (32 bytes >= 26)
REQ-033 SHALL cover the data pipe:
- stimulus: three back-to-back reads returning A, B, C
- required: fifo_rd_data/_d = A/0, B/A, C/B on successive cycles
REQ-034 SHALL cover forcetxstopmode:
- stimulus: assert at count 12
- required: next cycle count=0, state IDLE, no eop_wr
REQ-035 SHALL cover WC=0 with the macro defined:
- stimulus: long-packet header with WC=0
- required: pkt_err=1, count=6
- required: without the macro, pkt_err=0
REQ-036 SHALL cover simultaneous events:
- stimulus: header_info and a beat in the same cycle
- required: count takes the new header's load value
